hsv_rgb_arb: RTL and testbench

Arbitrates a single shared HSV-to-RGB conversion datapath between two requesters: a pixel stream path and a colour-key/overlay path. It accepts one HSV word at a time through a valid/ready handshake, normalises the hue, drives the converter input register, waits a programmable number of cycles for the converter's combinational path to settle, captures the RGB result and returns it to the owning requester. It sits between the filter stage and the shared converter instance in the video pipeline.

---
 rtl/hsv_rgb_arb_if.sv | 21 ++
 rtl/hsv_rgb_arb.sv | 122 ++++++++++++
 tb/tb_hsv_rgb_arb.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsv_rgb_arb_if.sv
// Request/response handshake bundle between the two requesters
// and the shared HSV-to-RGB arbiter.
interface hsv_rgb_arb_if;
    logic [1:0]  req_valid;
    logic [23:0] req_hsv0;
    logic [23:0] req_hsv1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [23:0] rsp_rgb;

    modport master (
        output req_valid, req_hsv0, req_hsv1, rsp_ready,
        input  req_ready, rsp_valid, rsp_rgb
    );

    modport slave (
        input  req_valid, req_hsv0, req_hsv1, rsp_ready,
        output req_ready, rsp_valid, rsp_rgb
    );
endinterface

// File: rtl/hsv_rgb_arb.sv
// Two-requester arbiter around a shared HSV-to-RGB converter:
// hue normalisation, settle wait, result capture and return.
module hsv_rgb_arb #(
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    hsv_rgb_arb_if.slave  bus,
    output logic [23:0]   cv_hsv,
    input  logic [23:0]   cv_rgb,
    output logic          busy,
    output logic [15:0]   wrap_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        pri;
    logic        tag;
    logic [3:0]  cnt;
    logic [15:0] wcnt;
    logic [1:0]  rvld;
    logic [23:0] rrgb;
    logic        bsy;

    logic [1:0]  grant;
    logic        gsel;
    logic [23:0] hsv_in;
    logic [8:0]  hue_in;
    logic        wrap;
    logic [8:0]  hue_n;

    // Grant is only offered in IDLE; pri breaks ties.
    always_comb begin
        grant = 2'b00;
        gsel  = 1'b0;
        if (state == IDLE) begin
            unique case (bus.req_valid)
                2'b01: begin
                    grant = 2'b01;
                    gsel  = 1'b0;
                end
                2'b10: begin
                    grant = 2'b10;
                    gsel  = 1'b1;
                end
                2'b11: begin
                    grant = pri ? 2'b10 : 2'b01;
                    gsel  = pri;
                end
                default: begin
                    grant = 2'b00;
                    gsel  = 1'b0;
                end
            endcase
        end
    end

    // Winner's word with hue folded back into 0..359.
    always_comb begin
        hsv_in = gsel ? bus.req_hsv1 : bus.req_hsv0;
        hue_in = hsv_in[23:15];
        wrap   = (hue_in >= 9'd360);
        hue_n  = wrap ? (hue_in - 9'd360) : hue_in;
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rvld;
    assign bus.rsp_rgb   = rrgb;
    assign busy          = bsy;
    assign wrap_cnt      = wcnt;

    // Accept, settle-wait, capture and hand back the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pri    <= 1'b0;
            tag    <= 1'b0;
            cnt    <= 4'd0;
            wcnt   <= 16'd0;
            rvld   <= 2'b00;
            rrgb   <= 24'd0;
            bsy    <= 1'b0;
            cv_hsv <= 24'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        cv_hsv <= {hue_n, hsv_in[14:0]};
                        tag    <= gsel;
                        cnt    <= 4'(LAT - 1);
                        bsy    <= 1'b1;
                        state  <= WAIT;
                        if (wrap && wcnt != 16'hFFFF)
                            wcnt <= wcnt + 16'd1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rrgb  <= cv_rgb;
                        rvld  <= tag ? 2'b10 : 2'b01;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[tag]) begin
                        rvld  <= 2'b00;
                        pri   <= ~tag;
                        bsy   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hsv_rgb_arb.sv
// Self-checking bench for hsv_rgb_arb: transaction-level model
// with per-cycle compare plus directed literal checks.
module tb_hsv_rgb_arb;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cv_hsv;
    logic [23:0] cv_rgb;
    logic        busy;
    logic [15:0] wrap_cnt;

    hsv_rgb_arb_if bus ();

    hsv_rgb_arb #(.LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cv_hsv   (cv_hsv),
        .cv_rgb   (cv_rgb),
        .busy     (busy),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in converter: R=V, G=V&~{S,1}, B=hue[7:0].
    function automatic logic [23:0] conv(input logic [23:0] x);
        logic [7:0] g;
        g = x[7:0] & ~{x[14:8], 1'b1};
        return {x[7:0], g, x[22:15]};
    endfunction

    function automatic logic [23:0] norm(input logic [23:0] x);
        logic [8:0] h;
        h = x[23:15];
        if (h >= 9'd360)
            h = h - 9'd360;
        return {h, x[14:0]};
    endfunction

    assign cv_rgb = conv(cv_hsv);

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;

    bit          m_act;
    bit          m_rsp;
    bit          m_own;
    bit          m_pri;
    int          m_age;
    logic [23:0] m_cv;
    logic [23:0] m_rgb;
    logic [15:0] m_wc;
    bit          w;
    logic [23:0] h;
    int          g_q[$];
    int          a_q[$];

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", n, a, e, $time);
        end
    endfunction

    // Transaction model: one job in flight, response LAT edges after accept.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0;
            m_rsp = 0;
            m_own = 0;
            m_pri = 0;
            m_age = 0;
            m_cv  = '0;
            m_rgb = '0;
            m_wc  = '0;
        end else begin
            cyc++;
            if (!m_act) begin
                if (bus.req_valid != 2'b00) begin
                    if (bus.req_valid == 2'b11)
                        w = m_pri;
                    else
                        w = bus.req_valid[1];
                    h = w ? bus.req_hsv1 : bus.req_hsv0;
                    m_act = 1;
                    m_own = w;
                    m_age = 0;
                    m_cv  = norm(h);
                    if (h[23:15] >= 9'd360 && m_wc != 16'hFFFF)
                        m_wc++;
                    g_q.push_back(int'(w));
                    a_q.push_back(cyc);
                    n_acc++;
                end
            end else if (m_rsp && bus.rsp_ready[m_own]) begin
                m_act = 0;
                m_rsp = 0;
                m_pri = !m_own;
            end else begin
                m_age++;
                if (m_age == LAT) begin
                    m_rsp = 1;
                    m_rgb = conv(m_cv);
                end
            end
        end
    end

    function automatic logic [1:0] exp_rdy();
        if (m_act)
            return 2'b00;
        if (bus.req_valid == 2'b11)
            return m_pri ? 2'b10 : 2'b01;
        return bus.req_valid;
    endfunction

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy()));
        chk("busy", 32'(busy), 32'(m_act));
        chk("rsp_valid", 32'(bus.rsp_valid),
            m_rsp ? (m_own ? 32'd2 : 32'd1) : 32'd0);
        chk("rsp_rgb", 32'(bus.rsp_rgb), 32'(m_rgb));
        chk("cv_hsv", 32'(cv_hsv), 32'(m_cv));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wc));
    end

    task automatic wait_acc(input int n);
        int tgt;
        bit ok;
        tgt = n_acc + n;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (n_acc >= tgt) begin
                ok = 1;
                break;
            end
        end
        if (!ok)
            chk("accept_timeout", 32'(n_acc), 32'(tgt));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (!m_act) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok)
            chk("idle_timeout", 32'(m_act), 32'd0);
    endtask

    task automatic wait_rsp(input int b, output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid[b]) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic send0(input logic [23:0] x);
        bus.req_hsv0  = x;
        bus.req_valid = 2'b01;
        wait_acc(1);
        bus.req_valid = 2'b00;
    endtask

    initial begin
        bit ok;
        bus.req_valid = 2'b00;
        bus.req_hsv0  = '0;
        bus.req_hsv1  = '0;
        bus.rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_cv_hsv", 32'(cv_hsv), 32'd0);
        chk("rst_wrap", 32'(wrap_cnt), 32'd0);
        rst = 1'b0;

        // contention: strict alternation, LAT+2 spacing
        bus.req_hsv0  = {9'd100, 7'd20, 8'd200};
        bus.req_hsv1  = {9'd300, 7'd90, 8'd60};
        bus.req_valid = 2'b11;
        wait_acc(4);
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++)
            chk("grant_order", 32'(g_q[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++)
            chk("accept_gap", 32'(a_q[i] - a_q[i-1]), 32'(LAT + 2));
        wait_idle();

        // single request
        bus.req_hsv0  = {9'd0, 7'd127, 8'd255};
        bus.req_valid = 2'b01;
        #1;
        chk("single_rdy", 32'(bus.req_ready), 32'd1);
        wait_acc(1);
        bus.req_valid = 2'b00;
        chk("single_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("single_early", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("single_vld", 32'(bus.rsp_valid), 32'd1);
        chk("single_rgb", 32'(bus.rsp_rgb), 32'hFF0000);
        chk("single_busy2", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("single_done", 32'(bus.rsp_valid), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);

        // hue wrap / no wrap
        send0({9'd400, 7'd5, 8'd9});
        chk("wrap_hue", 32'(cv_hsv[23:15]), 32'd40);
        chk("wrap_cnt1", 32'(wrap_cnt), 32'd1);
        wait_idle();
        send0({9'd359, 7'd5, 8'd9});
        chk("nowrap_hue", 32'(cv_hsv[23:15]), 32'd359);
        chk("nowrap_cnt", 32'(wrap_cnt), 32'd1);
        wait_idle();

        // response backpressure on requester 1
        bus.rsp_ready = 2'b01;
        bus.req_hsv1  = {9'd200, 7'd64, 8'd128};
        bus.req_valid = 2'b10;
        wait_acc(1);
        bus.req_valid = 2'b11;
        wait_rsp(1, ok);
        chk("bp_rsp_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 32'(bus.rsp_valid), 32'd2);
            chk("bp_rgb", 32'(bus.rsp_rgb), 32'h8000C8);
            chk("bp_rdy", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 2'b11;
        @(posedge clk);
        #1;
        chk("bp_done", 32'(bus.rsp_valid), 32'd0);
        chk("bp_next_rdy", 32'(bus.req_ready), 32'd1);
        wait_acc(1);
        bus.req_valid = 2'b00;
        wait_idle();

        // reset during WAIT
        send0({9'd450, 7'd3, 8'd77});
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_vld", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_cv", 32'(cv_hsv), 32'd0);
        chk("mid_rst_rgb", 32'(bus.rsp_rgb), 32'd0);
        chk("mid_rst_wrap", 32'(wrap_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_pulse", 32'(bus.rsp_valid), 32'd0);
        end
        send0({9'd10, 7'd1, 8'd2});
        wait_rsp(0, ok);
        chk("post_rst_rsp", 32'(ok), 32'd1);
        wait_idle();

        // wrap counter saturation
        @(posedge clk);
        #1;
        force dut.wcnt = 16'hFFFE;
        m_wc = 16'hFFFE;
        #1;
        release dut.wcnt;
        send0({9'd400, 7'd0, 8'd0});
        chk("sat_1", 32'(wrap_cnt), 32'hFFFF);
        wait_idle();
        send0({9'd511, 7'd0, 8'd0});
        chk("sat_2", 32'(wrap_cnt), 32'hFFFF);
        chk("sat_hue", 32'(cv_hsv[23:15]), 32'd151);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
